// File: rtl/m_spi_rx.sv
// m_spi_rx -- SPI slave receive stage.
//
// Oversamples sck/ss_n/mosi on the system clock, deserialises WORD-bit
// frames, buffers completed words in a first-word-fall-through FIFO and
// hands them to the consumer over a valid/ready handshake.
//
// Build option: define SPI_RX_LSB_FIRST_EN for LSB-first shifting;
// the default build shifts MSB-first to match m_p_to_s.
//
// Ports:
//   clk        system clock (16 MHz)
//   reset      asynchronous active-low reset
//   sck        SPI clock, idle low, asynchronous to clk
//   ss_n       slave select, active-low, asynchronous to clk
//   mosi       serial data, sampled on sck rising edge
//   rx_data    FIFO head word (0 while rx_valid=0)
//   rx_valid   FIFO not empty
//   rx_ready   consumer accepts head word
//   fifo_level words currently stored
//   overrun    sticky: completed word dropped, FIFO full
//   frame_err  sticky: ss_n released mid-frame
//   err_clr    synchronous clear of overrun and frame_err
module m_spi_rx #(
   parameter int WORD       = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sck,
   input  logic                          ss_n,
   input  logic                          mosi,
   output logic [WORD-1:0]               rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overrun,
   output logic                          frame_err,
   input  logic                          err_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic            sck_q1, sck_q2, sck_q3;
   logic            ss_q1, ss_q2;
   logic            mosi_q1, mosi_q2;
   logic            sck_rise;

   logic [0:0]      state;
   logic [WORD-1:0] sr;
   logic [WORD-1:0] sr_next;
   logic [CNT_W-1:0] bit_cnt;
   logic            last_bit;
   logic            abort_evt;

   logic            push_vld;
   logic [WORD-1:0] push_data;

   logic [WORD-1:0] mem [FIFO_DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic [AW:0]     level;
   logic            full;
   logic            do_pop, do_push, overrun_evt;

   // Synchronisers. ss_n resets to its idle (high) level so the FSM does
   // not start a frame straight out of reset. mosi uses the same depth as
   // sck so mosi_q2 is the bit that was on the pin at the sck rising edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sck_q1  <= 1'b0;
         sck_q2  <= 1'b0;
         sck_q3  <= 1'b0;
         ss_q1   <= 1'b1;
         ss_q2   <= 1'b1;
         mosi_q1 <= 1'b0;
         mosi_q2 <= 1'b0;
      end else begin
         sck_q1  <= sck;
         sck_q2  <= sck_q1;
         sck_q3  <= sck_q2;
         ss_q1   <= ss_n;
         ss_q2   <= ss_q1;
         mosi_q1 <= mosi;
         mosi_q2 <= mosi_q1;
      end
   end

   assign sck_rise = sck_q2 & ~sck_q3;

`ifdef SPI_RX_LSB_FIRST_EN
   assign sr_next = {mosi_q2, sr[WORD-1:1]};
`else
   assign sr_next = {sr[WORD-2:0], mosi_q2};
`endif

   assign last_bit  = (bit_cnt == CNT_W'(WORD - 1));
   assign abort_evt = (state == ST_SHIFT) && ss_q2 && (bit_cnt != '0);

   // Frame FSM. A completed word is registered into push_vld/push_data and
   // written into the FIFO on the following clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         sr        <= '0;
         bit_cnt   <= '0;
         push_vld  <= 1'b0;
         push_data <= '0;
      end else begin
         push_vld <= 1'b0;
         case (state)
            ST_IDLE: begin
               bit_cnt <= '0;
               if (!ss_q2) state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (ss_q2) begin
                  // Any partial word is simply discarded here.
                  state   <= ST_IDLE;
                  bit_cnt <= '0;
                  sr      <= '0;
               end else if (sck_rise) begin
                  sr <= sr_next;
                  if (last_bit) begin
                     push_vld  <= 1'b1;
                     push_data <= sr_next;
                     bit_cnt   <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // FIFO: pointers carry one extra wrap bit so full and empty differ.
   assign level       = wr_ptr - rd_ptr;
   assign full        = (level == (AW + 1)'(FIFO_DEPTH));
   assign rx_valid    = (wr_ptr != rd_ptr);
   assign do_pop      = rx_valid & rx_ready;
   // Popping while full frees the slot for a simultaneous push.
   assign do_push     = push_vld & (~full | do_pop);
   assign overrun_evt = push_vld & full & ~do_pop;
   assign fifo_level  = level;
   assign rx_data     = rx_valid ? mem[rd_ptr[AW-1:0]] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   // Sticky error flags; a new event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else if (err_clr) begin
         overrun   <= overrun_evt;
         frame_err <= abort_evt;
      end else begin
         overrun   <= overrun | overrun_evt;
         frame_err <= frame_err | abort_evt;
      end
   end

endmodule

// File: tb/tb_m_spi_rx.sv
// Testbench for m_spi_rx: directed SPI frames with a queue-based reference
// model checked every cycle, plus literal expectations per scenario.
module tb_m_spi_rx;

   logic       clk = 1'b0;
   logic       reset, sck, ss_n, mosi, rx_ready, err_clr;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [2:0] fifo_level;
   logic       overrun, frame_err;

   always #5 clk = ~clk;

   m_spi_rx dut (
      .clk(clk), .reset(reset), .sck(sck), .ss_n(ss_n), .mosi(mosi),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .fifo_level(fifo_level), .overrun(overrun), .frame_err(frame_err),
      .err_clr(err_clr)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      int         due;
      bit         is_push;
      logic [7:0] d;
   } ev_t;

   ev_t        evq[$];
   logic [7:0] mq[$];
   bit         m_ovr = 1'b0, m_ferr = 1'b0;
   bit         ev_fe, ev_ov;
   int         mbits = 0;
   logic [7:0] mcollect;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: words appear in the FIFO 4 clocks after the
   // pin-level sck rise that completes them; an abort is flagged 3 clocks
   // after ss_n rises. Pops happen before the push of the same cycle.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (reset) begin
         ev_fe = 1'b0;
         ev_ov = 1'b0;
         if (mq.size() > 0 && rx_ready) void'(mq.pop_front());
         for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].due == cyc) begin
               if (evq[i].is_push) begin
                  if (mq.size() == 4) ev_ov = 1'b1;
                  else mq.push_back(evq[i].d);
               end else begin
                  ev_fe = 1'b1;
               end
               evq.delete(i);
            end
         end
         if (err_clr) begin
            m_ovr  = ev_ov;
            m_ferr = ev_fe;
         end else begin
            m_ovr  = m_ovr | ev_ov;
            m_ferr = m_ferr | ev_fe;
         end
      end
   end

   always @(negedge clk) begin
      chk("valid", {31'd0, rx_valid}, {31'd0, (mq.size() != 0)});
      chk("level", {29'd0, fifo_level}, mq.size());
      chk("data", {24'd0, rx_data}, (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0);
      chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
   end

   function automatic logic bit_of(input logic [7:0] w, input int i);
`ifdef SPI_RX_LSB_FIRST_EN
      return w[i];
`else
      return w[7-i];
`endif
   endfunction

   // One sck period (4 clk low, 4 clk high). mode 1: probe the exact
   // rx_valid timing after the rise; mode 2: pulse rx_ready on the push cycle.
   task automatic send_bit(input logic b, input int mode, input logic [7:0] w);
      sck  = 1'b0;
      mosi = b;
      repeat (4) @(negedge clk);
      sck = 1'b1;
`ifdef SPI_RX_LSB_FIRST_EN
      mcollect[mbits % 8] = b;
`else
      mcollect[7 - (mbits % 8)] = b;
`endif
      mbits++;
      if (mbits % 8 == 0) evq.push_back(ev_t'{due: cyc + 4, is_push: 1'b1, d: mcollect});
      if (mode == 1) begin
         repeat (3) @(negedge clk);
         chk("t1_valid_early", {31'd0, rx_valid}, 32'd0);
         @(negedge clk);
         chk("t1_valid", {31'd0, rx_valid}, 32'd1);
         chk("t1_data", {24'd0, rx_data}, {24'd0, w});
         chk("t1_level", {29'd0, fifo_level}, 32'd1);
      end else if (mode == 2) begin
         repeat (3) @(negedge clk);
         rx_ready = 1'b1;
         @(negedge clk);
         rx_ready = 1'b0;
      end else begin
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic send_word(input logic [7:0] w, input int n, input int mode);
      for (int i = 0; i < n; i++) send_bit(bit_of(w, i), (i == n - 1) ? mode : 0, w);
   endtask

   task automatic ss_down();
      ss_n  = 1'b0;
      mbits = 0;
      repeat (4) @(negedge clk);
   endtask

   task automatic ss_up();
      sck  = 1'b0;
      ss_n = 1'b1;
      if (mbits % 8 != 0) evq.push_back(ev_t'{due: cyc + 3, is_push: 1'b0, d: 8'h00});
      repeat (6) @(negedge clk);
   endtask

   task automatic frame(input logic [7:0] w);
      ss_down();
      send_word(w, 8, 0);
      ss_up();
   endtask

   task automatic drain(input logic [7:0] e [4], input int n);
      rx_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         chk("drain_valid", {31'd0, rx_valid}, 32'd1);
         chk("drain_data", {24'd0, rx_data}, {24'd0, e[i]});
         @(negedge clk);
      end
      rx_ready = 1'b0;
   endtask

   task automatic clear_errs();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
      rx_ready = 1'b0; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_level", {29'd0, fifo_level}, 32'd0);
      chk("rst_errs", {30'd0, overrun, frame_err}, 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // T1 single frame, exact latency
      ss_down();
      send_word(8'hA5, 8, 1);
      ss_up();
      drain('{8'hA5, 8'h00, 8'h00, 8'h00}, 1);

      // T2 back-to-back frames in one ss_n window
      ss_down();
      send_word(8'h3C, 8, 0);
      send_word(8'hC3, 8, 0);
      ss_up();
      chk("t2_level", {29'd0, fifo_level}, 32'd2);
      drain('{8'h3C, 8'hC3, 8'h00, 8'h00}, 2);
      chk("t2_empty", {31'd0, rx_valid}, 32'd0);

      // T3 overrun
      for (int v = 1; v <= 5; v++) frame(8'(v));
      chk("t3_level", {29'd0, fifo_level}, 32'd4);
      chk("t3_overrun", {31'd0, overrun}, 32'd1);
      drain('{8'h01, 8'h02, 8'h03, 8'h04}, 4);
      chk("t3_empty", {31'd0, rx_valid}, 32'd0);
      clear_errs();
      chk("t3_clr", {31'd0, overrun}, 32'd0);

      // T4 push and pop in the same cycle while full
      frame(8'h11); frame(8'h22); frame(8'h33); frame(8'h44);
      ss_down();
      send_word(8'h77, 8, 2);
      ss_up();
      chk("t4_overrun", {31'd0, overrun}, 32'd0);
      chk("t4_level", {29'd0, fifo_level}, 32'd4);
      drain('{8'h22, 8'h33, 8'h44, 8'h77}, 4);

      // T5 aborted frame, then a clean one
      ss_down();
      send_word(8'hB6, 5, 0);
      ss_up();
      chk("t5_ferr", {31'd0, frame_err}, 32'd1);
      chk("t5_level", {29'd0, fifo_level}, 32'd0);
      frame(8'h5A);
      drain('{8'h5A, 8'h00, 8'h00, 8'h00}, 1);
      clear_errs();
      chk("t5_clr", {31'd0, frame_err}, 32'd0);

      // T6 reset mid-frame with two words stored
      frame(8'h12);
      frame(8'h34);
      chk("t6_level_pre", {29'd0, fifo_level}, 32'd2);
      ss_down();
      send_word(8'hFF, 3, 0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      sck   = 1'b0;
      ss_n  = 1'b1;
      mq.delete();
      evq.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      mbits  = 0;
      #1;
      chk("t6_valid", {31'd0, rx_valid}, 32'd0);
      chk("t6_level", {29'd0, fifo_level}, 32'd0);
      chk("t6_data", {24'd0, rx_data}, 32'd0);
      chk("t6_errs", {30'd0, overrun, frame_err}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      frame(8'hF0);
      drain('{8'hF0, 8'h00, 8'h00, 8'h00}, 1);
      chk("t6_ferr", {31'd0, frame_err}, 32'd0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
